// File: rtl/t5_pkg.sv
// Shared LSU constants: opcodes, funct3 codes, FSM states, lane helpers.
// Misaligned-trap option is selected in t5_lsu by T5_LSU_MISALIGN_EN.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    LSU_IDLE = 1'b0,
    LSU_BUSY = 1'b1
  } lsu_state_e;

  function automatic logic [3:0] lsu_sel(
    input logic [2:0] fn3,
    input logic [1:0] a
  );
    logic [3:0] s;
    s = 4'b0000;
    case (fn3)
      F3_B, F3_BU: s = 4'b0001 << a;
      F3_H, F3_HU: s = a[1] ? 4'b1100 : 4'b0011;
      F3_W:        s = 4'b1111;
      default:     s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic lsu_misalign(
    input logic [2:0] fn3,
    input logic [1:0] a
  );
    logic m;
    m = 1'b0;
    case (fn3)
      F3_H, F3_HU: m = a[0];
      F3_W:        m = |a;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/t5_lsu_align.sv
// Load-lane extraction: picks byte/half/word from the bus word
// and sign- or zero-extends it to 32 bits.
module t5_lsu_align
  import t5_pkg::*;
(
  input  logic [31:0] dat,
  input  logic [1:0]  adr,
  input  logic [2:0]  fn3,
  output logic [31:0] res
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b   = dat[{adr, 3'b000} +: 8];
    h   = adr[1] ? dat[31:16] : dat[15:0];
    res = '0;
    unique case (1'b1)
      fn3 == F3_B:  res = {{24{b[7]}}, b};
      fn3 == F3_BU: res = {24'd0, b};
      fn3 == F3_H:  res = {{16{h[15]}}, h};
      fn3 == F3_HU: res = {16'd0, h};
      fn3 == F3_W:  res = dat;
      default:      res = '0;
    endcase
  end

endmodule

// File: rtl/t5_lsu.sv
// Load/store unit: Wishbone-classic master with aligned load return.
// Define T5_LSU_MISALIGN_EN to trap misaligned half/word accesses.
module t5_lsu
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic            sena,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xbpc,
  input  logic [XLEN-1:0] xdat,
  output logic [XLEN-1:0] dwb_adr_o,
  output logic [XLEN-1:0] dwb_dat_o,
  output logic [3:0]      dwb_sel_o,
  output logic            dwb_we_o,
  output logic            dwb_stb_o,
  output logic            dwb_cyc_o,
  input  logic [XLEN-1:0] dwb_dat_i,
  input  logic            dwb_ack_i,
  output logic [XLEN-1:0] mdat,
  output logic            mstl,
  output logic            mexc
);

  lsu_state_e  state_q, state_d;
  logic        ld, st, busy, ack;
  logic        accept, mis, go;
  logic [2:0]  fn3_q;
  logic [1:0]  lane_q;
  logic [31:0] aligned;

  assign ld     = xopc == OPC_LOAD;
  assign st     = xopc == OPC_STORE;
  assign busy   = state_q == LSU_BUSY;
  assign ack    = busy & dwb_ack_i;
  assign accept = sena & (ld | st) & (~busy | dwb_ack_i);

`ifdef T5_LSU_MISALIGN_EN
  assign mis = lsu_misalign(xfn3, xbpc[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign go = accept & ~mis;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) state_q <= LSU_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (go) state_d = LSU_BUSY;
      LSU_BUSY: if (dwb_ack_i && !go) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Request registers load on accept, even on the ack edge of the previous access.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      dwb_adr_o <= '0;
      dwb_dat_o <= '0;
      dwb_sel_o <= '0;
      dwb_we_o  <= 1'b0;
      dwb_stb_o <= 1'b0;
      fn3_q     <= '0;
      lane_q    <= '0;
    end else if (go) begin
      dwb_adr_o <= {xbpc[XLEN-1:2], 2'b00};
      dwb_dat_o <= xdat;
      dwb_sel_o <= lsu_sel(xfn3, xbpc[1:0]);
      dwb_we_o  <= st;
      dwb_stb_o <= 1'b1;
      fn3_q     <= xfn3;
      lane_q    <= xbpc[1:0];
    end else if (ack) begin
      dwb_stb_o <= 1'b0;
    end
  end

  t5_lsu_align u_align (
    .dat (dwb_dat_i),
    .adr (lane_q),
    .fn3 (fn3_q),
    .res (aligned)
  );

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n)             mdat <= '0;
    else if (ack && !dwb_we_o) mdat <= aligned;
  end

`ifdef T5_LSU_MISALIGN_EN
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) mexc <= 1'b0;
    else         mexc <= accept & mis;
  end
`else
  assign mexc = 1'b0;
`endif

  assign dwb_cyc_o = dwb_stb_o;
  assign mstl      = busy & ~dwb_ack_i;

endmodule

// File: tb/tb_t5_lsu.sv
// Directed + random bench for t5_lsu against a lane-arithmetic model.
// Misaligned-trap checks follow T5_LSU_MISALIGN_EN when defined.
module tb_t5_lsu;

  logic        sclk = 1'b0;
  logic        srst_n;
  logic        sena;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] xbpc, xdat;
  logic [31:0] dwb_adr_o, dwb_dat_o;
  logic [3:0]  dwb_sel_o;
  logic        dwb_we_o, dwb_stb_o, dwb_cyc_o;
  logic [31:0] dwb_dat_i;
  logic        dwb_ack_i;
  logic [31:0] mdat;
  logic        mstl, mexc;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_mdat = '0;

  always #5 sclk = ~sclk;

  t5_lsu dut (
    .sclk      (sclk),
    .srst_n    (srst_n),
    .sena      (sena),
    .xopc      (xopc),
    .xfn3      (xfn3),
    .xbpc      (xbpc),
    .xdat      (xdat),
    .dwb_adr_o (dwb_adr_o),
    .dwb_dat_o (dwb_dat_o),
    .dwb_sel_o (dwb_sel_o),
    .dwb_we_o  (dwb_we_o),
    .dwb_stb_o (dwb_stb_o),
    .dwb_cyc_o (dwb_cyc_o),
    .dwb_dat_i (dwb_dat_i),
    .dwb_ack_i (dwb_ack_i),
    .mdat      (mdat),
    .mstl      (mstl),
    .mexc      (mexc)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_sel(input logic [2:0] f,
                                       input logic [31:0] a);
    int k;
    k = int'(a[1:0]);
    if (f == 3'd0 || f == 3'd4) return 4'(1 << k);
    if (f == 3'd1 || f == 3'd5) return a[1] ? 4'd12 : 4'd3;
    if (f == 3'd2) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = rd;
    if (f == 3'd0 || f == 3'd4) begin
      v = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      if (f == 3'd0 && v > 127) v = v + 32'hFFFF_FF00;
    end else if (f == 3'd1 || f == 3'd5) begin
      v = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      if (f == 3'd1 && v > 32767) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic req(input logic st, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d);
    sena = 1'b1;
    xopc = st ? 5'h08 : 5'h00;
    xfn3 = f;
    xbpc = a;
    xdat = d;
  endtask

  task automatic idle_in();
    sena = 1'b0;
    xopc = 5'h04;
  endtask

  // Full single access: request, w wait states, ack with rd, then check result.
  task automatic xfer(input string tag, input logic st, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] rd, input int w);
    int stalls;
    stalls = 0;
    req(st, f, a, d);
    @(posedge sclk); #1;
    idle_in();
    for (int i = 0; i <= w; i++) begin
      if (i == w) begin
        dwb_ack_i = 1'b1;
        dwb_dat_i = rd;
      end
      @(negedge sclk);
      if (mstl) stalls++;
      if (i == 0) begin
        chk({tag, ".stb"}, 32'(dwb_stb_o), 32'd1);
        chk({tag, ".cyc"}, 32'(dwb_cyc_o), 32'd1);
        chk({tag, ".adr"}, dwb_adr_o, {a[31:2], 2'b00});
        chk({tag, ".sel"}, 32'(dwb_sel_o), 32'(m_sel(f, a)));
        chk({tag, ".we"}, 32'(dwb_we_o), 32'(st));
        if (st) chk({tag, ".dat"}, dwb_dat_o, d);
      end
      if (i == w) chk({tag, ".stb_ack"}, 32'(dwb_stb_o), 32'd1);
      chk({tag, ".mdat_hold"}, mdat, exp_mdat);
      @(posedge sclk); #1;
    end
    dwb_ack_i = 1'b0;
    dwb_dat_i = $urandom;
    chk({tag, ".stalls"}, 32'(stalls), 32'(w));
    if (!st) exp_mdat = m_load(f, a, rd);
    @(negedge sclk);
    chk({tag, ".mdat"}, mdat, exp_mdat);
    chk({tag, ".stb_end"}, 32'(dwb_stb_o), 32'd0);
    chk({tag, ".mstl_end"}, 32'(mstl), 32'd0);
    @(posedge sclk); #1;
  endtask

  initial begin
    logic        rst_st;
    logic [2:0]  rf;
    logic [31:0] ra;

    srst_n    = 1'b0;
    dwb_ack_i = 1'b0;
    dwb_dat_i = '0;
    xfn3      = '0;
    xbpc      = '0;
    xdat      = '0;
    idle_in();
    #12;
    chk("rst.stb", 32'(dwb_stb_o), 32'd0);
    chk("rst.cyc", 32'(dwb_cyc_o), 32'd0);
    chk("rst.mstl", 32'(mstl), 32'd0);
    chk("rst.mdat", mdat, 32'd0);
    chk("rst.mexc", 32'(mexc), 32'd0);
    chk("rst.adr", dwb_adr_o, 32'd0);
    chk("rst.sel", 32'(dwb_sel_o), 32'd0);
    srst_n = 1'b1;
    @(posedge sclk); #1;

    // Stray ack while idle is ignored
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'h1234_5678;
    @(posedge sclk); #1;
    dwb_ack_i = 1'b0;
    @(negedge sclk);
    chk("idle_ack.stb", 32'(dwb_stb_o), 32'd0);
    chk("idle_ack.mdat", mdat, 32'd0);
    @(posedge sclk); #1;

    xfer("t1_lw", 1'b0, 3'd2, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
    xfer("t2_lb", 1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0011, 0);
    chk("t2_lb.val", mdat, 32'hFFFF_FF80);
    xfer("t2_lbu", 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0011, 1);
    chk("t2_lbu.val", mdat, 32'h0000_0080);
    xfer("t3_sh", 1'b1, 3'd1, 32'h202, 32'h1234_1234, 32'h5555_AAAA, 3);
    chk("t3_sh.mdat", mdat, 32'h0000_0080);

    // Back-to-back SW then LH on the ack cycle
    req(1'b1, 3'd2, 32'h300, 32'hCAFE_F00D);
    @(posedge sclk); #1;
    idle_in();
    @(negedge sclk);
    chk("t4.sw_stb", 32'(dwb_stb_o), 32'd1);
    chk("t4.sw_mstl", 32'(mstl), 32'd1);
    @(posedge sclk); #1;
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'h0BAD_0BAD;
    req(1'b0, 3'd1, 32'h306, 32'h0);
    @(negedge sclk);
    chk("t4.ack_mstl", 32'(mstl), 32'd0);
    @(posedge sclk); #1;
    dwb_ack_i = 1'b0;
    idle_in();
    @(negedge sclk);
    chk("t4.lh_stb", 32'(dwb_stb_o), 32'd1);
    chk("t4.lh_adr", dwb_adr_o, 32'h304);
    chk("t4.lh_sel", 32'(dwb_sel_o), 32'hC);
    chk("t4.lh_we", 32'(dwb_we_o), 32'd0);
    chk("t4.sw_mdat", mdat, exp_mdat);
    @(posedge sclk); #1;
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'h8001_1234;
    @(posedge sclk); #1;
    dwb_ack_i = 1'b0;
    exp_mdat = 32'hFFFF_8001;
    @(negedge sclk);
    chk("t4.lh_mdat", mdat, exp_mdat);
    chk("t4.end_stb", 32'(dwb_stb_o), 32'd0);
    @(posedge sclk); #1;

    // Async reset while busy
    req(1'b0, 3'd2, 32'h400, 32'h0);
    @(posedge sclk); #1;
    idle_in();
    #2;
    chk("t5.busy_stb", 32'(dwb_stb_o), 32'd1);
    srst_n = 1'b0;
    #1;
    chk("t5.stb", 32'(dwb_stb_o), 32'd0);
    chk("t5.cyc", 32'(dwb_cyc_o), 32'd0);
    chk("t5.mstl", 32'(mstl), 32'd0);
    exp_mdat = '0;
    chk("t5.mdat", mdat, exp_mdat);
    #3;
    srst_n = 1'b1;
    @(posedge sclk); #1;
    dwb_ack_i = 1'b1;
    dwb_dat_i = 32'hAAAA_5555;
    @(posedge sclk); #1;
    @(posedge sclk); #1;
    dwb_ack_i = 1'b0;
    @(negedge sclk);
    chk("t5.stray_mdat", mdat, exp_mdat);
    chk("t5.stray_stb", 32'(dwb_stb_o), 32'd0);
    @(posedge sclk); #1;

`ifdef T5_LSU_MISALIGN_EN
    req(1'b0, 3'd2, 32'h101, 32'h0);
    @(posedge sclk); #1;
    idle_in();
    @(negedge sclk);
    chk("t6.stb", 32'(dwb_stb_o), 32'd0);
    chk("t6.mexc", 32'(mexc), 32'd1);
    @(posedge sclk); #1;
    @(negedge sclk);
    chk("t6.mexc_end", 32'(mexc), 32'd0);
    chk("t6.mstl", 32'(mstl), 32'd0);
    @(posedge sclk); #1;
`else
    xfer("t6_lw_mis", 1'b0, 3'd2, 32'h101, 32'h0, 32'h0102_0304, 0);
    chk("t6.mexc", 32'(mexc), 32'd0);
`endif

    // Random aligned traffic
    for (int n = 0; n < 40; n++) begin
      rst_st = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0:       rf = 3'd0;
        1:       rf = 3'd1;
        2:       rf = 3'd2;
        3:       rf = 3'd4;
        default: rf = 3'd5;
      endcase
      if (rst_st) rf[2] = 1'b0;
      ra = $urandom;
      if (rf[1:0] == 2'd1) ra[0] = 1'b0;
      if (rf == 3'd2) ra[1:0] = 2'b00;
      xfer("rnd", rst_st, rf, ra, $urandom, $urandom,
           int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
